// File: rtl/fp_pkg.sv
// Shared definitions for the binary32-to-integer converter.
// Holds the binary32 field widths and exponent bias, the out_flags bit
// indices, the unpacked-float view of an operand, and the stage-1 payload
// that travels between the two pipeline stages.
package fp_pkg;

   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;
   localparam int EXP_BIAS = 127;
   localparam int MANT_W   = FRAC_W + 1;   // mantissa with its hidden bit
   localparam int MAG_W    = 32;           // widest integer part carried to stage 2

   localparam int FLAG_INEXACT  = 0;
   localparam int FLAG_OVERFLOW = 1;
   localparam int FLAG_INVALID  = 2;
   localparam int FLAGS_W       = 3;

   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   // Operand after unpack and alignment: integer part plus rounding bits.
   typedef struct packed {
      logic             sign;
      logic             is_nan;
      logic             is_inf;
      logic             big;      // integer part cannot fit in INT_W bits
      logic [MAG_W-1:0] mag;
      logic             guard;
      logic             sticky;
   } align_t;

endpackage

// File: rtl/fp_align_shift.sv
// Combinational mantissa aligner.
// Scales the 24-bit mantissa by 2^(exp-150), i.e. by 2^(e-23) with
// e = exp-127, returning the integer part, the first discarded bit (guard)
// and the OR of all further discarded bits (sticky).
// Ports:
//   mant     in  24  mantissa including hidden bit (0 for zero/subnormal)
//   exp      in  8   biased exponent
//   int_part out 32  integer part (only meaningful for e <= 31)
//   guard    out 1   bit of weight 2^-1
//   sticky   out 1   OR of bits below 2^-1
module fp_align_shift
   import fp_pkg::*;
(
   input  logic [MANT_W-1:0] mant,
   input  logic [EXP_W-1:0]  exp,
   output logic [MAG_W-1:0]  int_part,
   output logic              guard,
   output logic              sticky
);

   // Exponent at which the mantissa LSB has weight 1 (e == 23).
   localparam logic [EXP_W-1:0] EXP_UNIT = EXP_W'(EXP_BIAS + FRAC_W);
   // Exponent at which the hidden bit has weight 2^-1 (e == -1).
   localparam logic [EXP_W-1:0] EXP_HALF = EXP_W'(EXP_BIAS - 1);

   logic [EXP_W-1:0]  rsh;
   logic [EXP_W-1:0]  lsh;
   logic [MANT_W-1:0] low_mask;

   always_comb begin
      // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
      rsh      = EXP_UNIT - exp;
      lsh      = exp - EXP_UNIT;
      low_mask = '0;
      int_part = '0;
      guard    = 1'b0;
      sticky   = 1'b0;
      if (exp < EXP_HALF) begin
         sticky = |mant;
      end else if (exp == EXP_HALF) begin
         guard  = mant[MANT_W-1];
         sticky = |mant[MANT_W-2:0];
      end else if (exp <= EXP_UNIT) begin
         // low_mask covers the rsh discarded bits; its top bit is the guard.
         low_mask = (MANT_W'(1) << rsh) - MANT_W'(1);
         int_part = MAG_W'(mant >> rsh);
         guard    = |(mant & (low_mask ^ (low_mask >> 1)));
         sticky   = |(mant & (low_mask >> 1));
      end else begin
         int_part = MAG_W'(mant) << lsh;
      end
   end

endmodule

// File: rtl/fp32_to_int.sv
// IEEE-754 binary32 to signed INT_W-bit integer converter, 2-stage pipeline
// with valid/ready handshakes on both sides.
//   stage 1: unpack, classify, align mantissa (guard/sticky)
//   stage 2: round, negate, saturate, build flags
// Rounding: truncation toward zero by default; round-to-nearest-even when
// the macro FP2INT_RNE_EN is defined. inexact is reported in both builds.
// Ports:
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous active-high reset
//   in_valid  in   1      in_data holds an operand
//   in_ready  out  1      operand accepted this cycle when in_valid
//   in_data   in   32     binary32 operand
//   out_valid out  1      out_data/out_flags hold a result
//   out_ready in   1      consumer takes the result this cycle
//   out_data  out  INT_W  two's-complement result
//   out_flags out  3      {invalid, overflow, inexact}
module fp32_to_int
   import fp_pkg::*;
#(
   parameter int INT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INT_W-1:0]   out_data,
   output logic [FLAGS_W-1:0] out_flags
);

   localparam logic [INT_W:0]   HALF_RANGE = {2'b01, {(INT_W-1){1'b0}}};   // 2^(INT_W-1)
   localparam logic [INT_W-1:0] SAT_POS    = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic [INT_W-1:0] SAT_NEG    = {1'b1, {(INT_W-1){1'b0}}};
   localparam logic [EXP_W:0]   EXP_BIG    = (EXP_W+1)'(EXP_BIAS + INT_W);

   fp32_t              in_fp;
   logic [MANT_W-1:0]  in_mant;
   logic [MAG_W-1:0]   sh_int;
   logic               sh_guard;
   logic               sh_sticky;

   logic               s1_en;
   logic               s2_en;
   logic               s1_valid_d, s1_valid_q;
   logic               s2_valid_d, s2_valid_q;
   align_t             s1_d, s1_q;
   logic [INT_W-1:0]   s2_data_d, s2_data_q;
   logic [FLAGS_W-1:0] s2_flags_d, s2_flags_q;

   logic               round_up;
   logic [INT_W:0]     mag_r;
   logic [INT_W:0]     neg_mag;
   logic               ovf;
   logic [INT_W-1:0]   res_data;
   logic [FLAGS_W-1:0] res_flags;

   assign in_fp   = in_data;
   // Zero and subnormals get no hidden bit, so they align to magnitude 0.
   assign in_mant = {in_fp.exp != '0, in_fp.frac};

   fp_align_shift u_align (
      .mant     (in_mant),
      .exp      (in_fp.exp),
      .int_part (sh_int),
      .guard    (sh_guard),
      .sticky   (sh_sticky)
   );

   // A stage can load when it is empty or its content moves on this cycle;
   // bubbles are squeezed out and in_ready never depends on in_valid.
   assign s2_en     = !s2_valid_q || out_ready;
   assign s1_en     = !s1_valid_q || s2_en;
   assign in_ready  = s1_en;
   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_flags = s2_flags_q;

   // Stage 1: unpack and align.
   always_comb begin
      s1_valid_d = s1_en ? in_valid : s1_valid_q;
      s1_d       = s1_q;
      if (s1_en) begin
         s1_d.sign   = in_fp.sign;
         s1_d.is_nan = (in_fp.exp == EXP_MAX) && (in_fp.frac != '0);
         s1_d.is_inf = (in_fp.exp == EXP_MAX) && (in_fp.frac == '0);
         s1_d.big    = {1'b0, in_fp.exp} >= EXP_BIG;
         s1_d.mag    = sh_int;
         s1_d.guard  = sh_guard;
         s1_d.sticky = sh_sticky;
      end
   end

   // Stage 2: round, negate, saturate.
   always_comb begin
      round_up = 1'b0;
`ifdef FP2INT_RNE_EN
      round_up = s1_q.guard && (s1_q.sticky || s1_q.mag[0]);
`endif
      mag_r   = {1'b0, s1_q.mag[INT_W-1:0]} + (INT_W+1)'(round_up);
      neg_mag = -mag_r;
      // The most negative value has one more unit of magnitude than the most positive.
      ovf     = s1_q.big || (s1_q.sign ? (mag_r > HALF_RANGE) : (mag_r >= HALF_RANGE));

      res_flags = '0;
      if (s1_q.is_nan) begin
         res_data                = SAT_POS;
         res_flags[FLAG_INVALID] = 1'b1;
      end else if (s1_q.is_inf) begin
         res_data                 = s1_q.sign ? SAT_NEG : SAT_POS;
         res_flags[FLAG_OVERFLOW] = 1'b1;
      end else begin
         res_flags[FLAG_INEXACT] = s1_q.guard || s1_q.sticky;
         if (ovf) begin
            res_data                 = s1_q.sign ? SAT_NEG : SAT_POS;
            res_flags[FLAG_OVERFLOW] = 1'b1;
         end else begin
            res_data = s1_q.sign ? neg_mag[INT_W-1:0] : mag_r[INT_W-1:0];
         end
      end

      s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_flags_d = s2_flags_q;
      if (s2_en && s1_valid_q) begin
         s2_data_d  = res_data;
         s2_flags_d = res_flags;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so all flops update together.
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_flags_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_flags_q <= s2_flags_d;
      end
   end

   // NOTE: the stage-1 payload is not reset; s1_valid_q qualifies every use of it.
   always_ff @(posedge clk) begin
      s1_q <= s1_d;
   end

endmodule

// File: tb/tb_fp32_to_int.sv
// Self-checking bench for fp32_to_int (INT_W = 32).
// Directed vectors cover rounding, saturation and special values; a
// randomized stream with random backpressure is scored against an
// arithmetic reference model. Honors FP2INT_RNE_EN like the design.
module tb_fp32_to_int;

   localparam int INT_W = 32;
`ifdef FP2INT_RNE_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif
   localparam logic [INT_W-1:0] MAXP = 32'h7FFF_FFFF;
   localparam logic [INT_W-1:0] MINN = 32'h8000_0000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [INT_W-1:0] out_data;
   logic [2:0]       out_flags;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0]      x;
      logic [INT_W-1:0] d;
      logic [2:0]       f;
   } vec_t;

   always #5 clk = ~clk;

   fp32_to_int #(.INT_W(INT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: exact value mant*2^(e-23) split into integer part and
   // remainder, rounded by comparing the remainder with one half.
   function automatic void model(input logic [31:0] x, output logic [INT_W-1:0] d,
                                 output logic [2:0] f);
      bit     s    = x[31];
      int     ex   = int'(x[30:23]);
      longint frac = longint'(x[22:0]);
      longint mant, ip, rem, half, mag, v, lim;
      int     e, sh;
      bit     up, inex;
      lim = longint'(1) << (INT_W - 1);
      if (ex == 255) begin
         if (frac != 0) begin d = MAXP; f = 3'b100; end
         else begin d = s ? MINN : MAXP; f = 3'b010; end
         return;
      end
      mant = (ex == 0) ? frac : (frac | (longint'(1) << 23));
      e    = (ex == 0) ? -126 : ex - 127;
      if (e >= 40) begin
         d = s ? MINN : MAXP; f = 3'b010;
         return;
      end
      up = 1'b0;
      if (e >= 23) begin
         ip  = mant << (e - 23);
         rem = 0;
      end else begin
         sh = 23 - e;
         if (sh >= 40) begin
            ip  = 0;
            rem = mant;
         end else begin
            ip   = mant >> sh;
            rem  = mant - (ip << sh);
            half = longint'(1) << (sh - 1);
            up   = (rem > half) || (rem == half && ip[0]);
         end
      end
      inex = (rem != 0);
      if (!RNE) up = 1'b0;
      mag = ip + longint'(up);
      v   = s ? -mag : mag;
      if (v > lim - 1) begin d = MAXP; f = {2'b01, inex}; end
      else if (v < -lim) begin d = MINN; f = {2'b01, inex}; end
      else begin d = v[INT_W-1:0]; f = {2'b00, inex}; end
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [7:0] ex;
      int         r = int'($urandom_range(0, 9));
      if (r == 0)      ex = 8'd0;
      else if (r == 1) ex = 8'd255;
      else             ex = 8'($urandom_range(110, 162));
      return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
   endfunction

   // Sends one operand into an idle pipeline and waits for its result.
   task automatic run_one(input logic [31:0] x, output logic [INT_W-1:0] d,
                          output logic [2:0] f, output int lat);
      @(posedge clk); #1;
      in_data = x; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
      if (!out_valid) lat = 99;
      d = out_data;
      f = out_flags;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL reset_out_flags got %b want 000", out_flags); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (out_data !== '0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle got data %h valid %b want 0/0", out_data, out_valid);
      end
   endtask

   task automatic test_rounding();
      vec_t             v[$];
      logic [INT_W-1:0] d;
      logic [2:0]       f;
      int               lat;
      v.push_back('{32'h3F80_0000, 32'd1, 3'b000});                               // 1.0
      v.push_back('{32'h4060_0000, RNE ? 32'd4 : 32'd3, 3'b001});                 // 3.5
      v.push_back('{32'h4020_0000, 32'd2, 3'b001});                               // 2.5
      v.push_back('{32'hC020_0000, 32'hFFFF_FFFE, 3'b001});                       // -2.5
      v.push_back('{32'hC060_0000, RNE ? 32'hFFFF_FFFC : 32'hFFFF_FFFD, 3'b001}); // -3.5
      v.push_back('{32'h3F00_0000, 32'd0, 3'b001});                               // 0.5
      v.push_back('{32'h3F40_0000, RNE ? 32'd1 : 32'd0, 3'b001});                 // 0.75
      v.push_back('{32'h3E80_0000, 32'd0, 3'b001});                               // 0.25
      v.push_back('{32'h4B00_0001, 32'd8388609, 3'b000});                         // 2^23+1
      v.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000});                       // largest below 2^31
      foreach (v[i]) begin
         run_one(v[i].x, d, f, lat);
         checks++; if (lat !== 2) begin errors++; $display("FAIL latency_%h got %0d want 2", v[i].x, lat); end
         checks++; if (d !== v[i].d) begin errors++; $display("FAIL round_data_%h got %h want %h", v[i].x, d, v[i].d); end
         checks++; if (f !== v[i].f) begin errors++; $display("FAIL round_flags_%h got %b want %b", v[i].x, f, v[i].f); end
      end
   endtask

   task automatic test_saturation_specials();
      vec_t             v[$];
      logic [INT_W-1:0] d;
      logic [2:0]       f;
      int               lat;
      v.push_back('{32'h4F00_0000, MAXP, 3'b010});   // 2^31
      v.push_back('{32'hCF00_0000, MINN, 3'b000});   // -2^31 exactly
      v.push_back('{32'hCF00_0001, MINN, 3'b010});   // just below -2^31
      v.push_back('{32'h5F00_0000, MAXP, 3'b010});   // 2^63
      v.push_back('{32'h7FC0_0000, MAXP, 3'b100});   // NaN
      v.push_back('{32'hFFC0_0001, MAXP, 3'b100});   // negative NaN
      v.push_back('{32'h7F80_0000, MAXP, 3'b010});   // +Inf
      v.push_back('{32'hFF80_0000, MINN, 3'b010});   // -Inf
      v.push_back('{32'h0000_0000, 32'd0, 3'b000});  // +0
      v.push_back('{32'h8000_0000, 32'd0, 3'b000});  // -0
      v.push_back('{32'h0000_0001, 32'd0, 3'b001});  // subnormal
      foreach (v[i]) begin
         run_one(v[i].x, d, f, lat);
         checks++; if (lat !== 2) begin errors++; $display("FAIL sat_latency_%h got %0d want 2", v[i].x, lat); end
         checks++; if (d !== v[i].d) begin errors++; $display("FAIL sat_data_%h got %h want %h", v[i].x, d, v[i].d); end
         checks++; if (f !== v[i].f) begin errors++; $display("FAIL sat_flags_%h got %b want %b", v[i].x, f, v[i].f); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0]      ops[3] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
      logic [INT_W-1:0] got_d[$];
      logic [2:0]       got_f[$];
      int               idx = 0;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk); #1;
         out_ready = (c >= 5);
         in_valid  = (idx < 3);
         if (idx < 3) in_data = ops[idx];
         @(negedge clk);
         if (c == 2) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
         end
         if (c >= 2 && c <= 4) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 32'd1) begin
               errors++; $display("FAIL bp_hold c%0d got valid %b data %h want 1/1", c, out_valid, out_data);
            end
         end
         if (out_valid && out_ready) begin got_d.push_back(out_data); got_f.push_back(out_flags); end
         if (in_valid && in_ready) idx++;
      end
      in_valid = 1'b0;
      checks++; if (got_d.size() !== 3) begin errors++; $display("FAIL bp_count got %0d want 3", got_d.size()); end
      for (int i = 0; i < 3 && i < got_d.size(); i++) begin
         checks++; if (got_d[i] !== INT_W'(i + 1) || got_f[i] !== 3'b000) begin
            errors++; $display("FAIL bp_order_%0d got %h/%b want %h/000", i, got_d[i], got_f[i], i + 1);
         end
      end
   endtask

   task automatic test_random_stream();
      logic [INT_W-1:0] exp_d[$];
      logic [2:0]       exp_f[$];
      logic [INT_W-1:0] md, hold_d, want_d;
      logic [2:0]       mf, hold_f, want_f;
      bit               hold = 1'b0;
      bit               acc  = 1'b1;
      int               sent = 0;
      int               recv = 0;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (acc || !in_valid) begin
            in_valid = (sent < 400) && ($urandom_range(0, 4) != 0);
            in_data  = rand_fp();
         end
         @(negedge clk);
         if (hold && out_valid) begin
            checks++; if (out_data !== hold_d || out_flags !== hold_f) begin
               errors++; $display("FAIL rnd_stable got %h/%b want %h/%b", out_data, out_flags, hold_d, hold_f);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_d.size() == 0) begin
               errors++; $display("FAIL rnd_extra got %h want none", out_data);
            end else begin
               want_d = exp_d.pop_front(); want_f = exp_f.pop_front(); recv++;
               if (out_data !== want_d || out_flags !== want_f) begin
                  errors++; $display("FAIL rnd_result_%0d got %h/%b want %h/%b", recv, out_data, out_flags, want_d, want_f);
               end
            end
         end
         hold   = out_valid && !out_ready;
         hold_d = out_data;
         hold_f = out_flags;
         acc    = in_valid && in_ready;
         if (acc) begin
            model(in_data, md, mf);
            exp_d.push_back(md); exp_f.push_back(mf); sent++;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (exp_d.size() == 0) begin
               errors++; $display("FAIL rnd_drain_extra got %h want none", out_data);
            end else begin
               want_d = exp_d.pop_front(); want_f = exp_f.pop_front();
               if (out_data !== want_d || out_flags !== want_f) begin
                  errors++; $display("FAIL rnd_drain got %h/%b want %h/%b", out_data, out_flags, want_d, want_f);
               end
            end
         end
      end
      checks++; if (exp_d.size() !== 0) begin errors++; $display("FAIL rnd_lost got %0d pending want 0", exp_d.size()); end
   endtask

   task automatic test_reset_inflight();
      int stale = 0;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h3F80_0000;
      @(posedge clk); #1;
      in_data = 32'h4000_0000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL inflight_full got valid %b ready %b want 1/0", out_valid, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flush_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_flush_ready got %b want 1", in_ready); end
      checks++; if (out_data !== '0 || out_flags !== 3'b000) begin
         errors++; $display("FAIL rst_flush_data got %h/%b want 0/000", out_data, out_flags);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      checks++; if (stale !== 0) begin errors++; $display("FAIL rst_stale got %0d results want 0", stale); end
   endtask

   initial begin
      test_reset();
      test_rounding();
      test_saturation_specials();
      test_backpressure();
      test_random_stream();
      test_reset_inflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
